// File: rtl/fp_result_disp_seq.sv
// Shows a captured 32-bit FPU result on the seven-segment driver one byte at a time, MSB first.
// Define FP_DISP_SEQ_LOOP_EN to make the sequence repeat and accept new results while it runs.
module fp_result_disp_seq #(
    parameter logic [31:0] DWELL_CYCLES = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result,
    input  logic        result_valid,
    output logic        result_ready,
    input  logic        next,
    output logic [7:0]  char,
    output logic [1:0]  byte_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;
    localparam logic [31:0] DWELL_LAST = DWELL_CYCLES - 32'd1;

    logic [0:0]  state_reg;
    logic [31:0] word_reg;
    logic [31:0] cnt_reg;
    logic [1:0]  idx_reg;
    logic [7:0]  char_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [7:0]  word_bytes [4];
    logic        accept;
    logic        advance;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

`ifdef FP_DISP_SEQ_LOOP_EN
    assign result_ready = 1'b1;
`else
    assign result_ready = (state_reg == ST_IDLE);
`endif

    assign accept  = result_valid && result_ready;
    // Expiry and a skip pulse in the same cycle collapse into a single advance.
    assign advance = (state_reg == ST_SHOW) && ((cnt_reg == DWELL_LAST) || next);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            word_reg  <= 32'h0;
            cnt_reg   <= 32'h0;
            idx_reg   <= 2'd3;
            char_reg  <= 8'h00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                // The first byte is taken straight from the input so it appears one cycle later.
                word_reg  <= result;
                idx_reg   <= 2'd3;
                cnt_reg   <= 32'h0;
                char_reg  <= result[31:24];
                busy_reg  <= 1'b1;
                state_reg <= ST_SHOW;
            end else if (state_reg == ST_SHOW) begin
                if (advance) begin
                    cnt_reg <= 32'h0;
                    if (idx_reg != 2'd0) begin
                        idx_reg  <= idx_reg - 2'd1;
                        char_reg <= word_bytes[idx_reg - 2'd1];
                    end else begin
                        done_reg <= 1'b1;
`ifdef FP_DISP_SEQ_LOOP_EN
                        idx_reg  <= 2'd3;
                        char_reg <= word_bytes[3];
`else
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
`endif
                    end
                end else begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    end

    assign char     = char_reg;
    assign byte_idx = idx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_fp_result_disp_seq.sv
// Directed bench for fp_result_disp_seq: cycle table on a short-dwell instance plus skip/loop sequences.
module tb_fp_result_disp_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] result = 32'h0;
    logic        result_valid = 1'b0;
    logic        next = 1'b0;

    logic        r4, b4, d4, r100, b100, d100;
    logic [7:0]  c4, c100;
    logic [1:0]  i4, i100;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_result_disp_seq #(.DWELL_CYCLES(32'd4)) dut4 (
        .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
        .result_ready(r4), .next(next), .char(c4), .byte_idx(i4), .busy(b4), .done(d4)
    );

    fp_result_disp_seq #(.DWELL_CYCLES(32'd100)) dut100 (
        .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
        .result_ready(r100), .next(next), .char(c100), .byte_idx(i100), .busy(b100), .done(d100)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] res;
        logic        nxt;
        int          reps;
        logic [7:0]  ch;
        logic [1:0]  idx;
        logic        busy;
        logic        done;
        logic        ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [31:0] d, logic n, int reps,
                                logic [7:0] ch, logic [1:0] idx, logic bz, logic dn, logic rd);
        vec_t t;
        t.rst = r; t.valid = v; t.res = d; t.nxt = n; t.reps = reps;
        t.ch = ch; t.idx = idx; t.busy = bz; t.done = dn; t.ready = rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic n);
        rst = r; result_valid = v; result = d; next = n;
    endtask

    initial begin
        int done_cnt;

        // rst valid result next reps | char idx busy done ready
        vecs.push_back(mk(1, 0, 32'h0,        0, 2, 8'h00, 2'd3, 0, 0, 1)); // reset
        vecs.push_back(mk(0, 1, 32'h40490FDB, 0, 1, 8'h40, 2'd3, 1, 0, 0)); // accept
        vecs.push_back(mk(0, 0, 32'h0,        0, 3, 8'h40, 2'd3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4, 8'h49, 2'd2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4, 8'h0F, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4, 8'hDB, 2'd0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 8'hDB, 2'd0, 0, 1, 1)); // done
        vecs.push_back(mk(0, 0, 32'h0,        0, 3, 8'hDB, 2'd0, 0, 0, 1)); // idle hold
        vecs.push_back(mk(0, 1, 32'h12345678, 0, 1, 8'h12, 2'd3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 3, 8'h12, 2'd3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 8'h34, 2'd2, 1, 0, 0)); // next at expiry
        vecs.push_back(mk(0, 0, 32'h0,        0, 3, 8'h34, 2'd2, 1, 0, 0)); // single advance
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 8'h56, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 3, 8'h56, 2'd1, 1, 0, 0)); // valid ignored
        vecs.push_back(mk(0, 0, 32'h0,        0, 4, 8'h78, 2'd0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 8'h78, 2'd0, 0, 1, 1)); // done
        vecs.push_back(mk(0, 1, 32'hAABBCCDD, 0, 1, 8'hAA, 2'd3, 1, 0, 0)); // back-to-back
        vecs.push_back(mk(0, 0, 32'h0,        0, 3, 8'hAA, 2'd3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 8'hBB, 2'd2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 8'h00, 2'd3, 0, 0, 1)); // mid reset
        vecs.push_back(mk(0, 0, 32'h0,        0, 5, 8'h00, 2'd3, 0, 0, 1)); // no done

        drive(1, 0, 32'h0, 0);
        step();

`ifndef FP_DISP_SEQ_LOOP_EN
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].rst, vecs[i].valid, vecs[i].res, vecs[i].nxt);
                step();
                chk($sformatf("row%0d.%0d char", i, r),  32'(c4), 32'(vecs[i].ch));
                chk($sformatf("row%0d.%0d idx", i, r),   32'(i4), 32'(vecs[i].idx));
                chk($sformatf("row%0d.%0d busy", i, r),  32'(b4), 32'(vecs[i].busy));
                chk($sformatf("row%0d.%0d done", i, r),  32'(d4), 32'(vecs[i].done));
                chk($sformatf("row%0d.%0d ready", i, r), 32'(r4), 32'(vecs[i].ready));
            end
            $display("row %0d rst=%0b valid=%0b result=%h next=%0b reps=%0d char=%h idx=%0d",
                     i, vecs[i].rst, vecs[i].valid, vecs[i].res, vecs[i].nxt, vecs[i].reps, c4, i4);
        end
`else
        // Reset row only; the remaining rows describe one-shot behaviour.
        drive(1, 0, 32'h0, 0);
        step(); step();
        chk("loop reset char", 32'(c4), 32'h00);
        chk("loop reset idx", 32'(i4), 32'd3);
        chk("loop reset busy", 32'(b4), 32'd0);
        chk("loop reset done", 32'(d4), 32'd0);
        chk("loop reset ready", 32'(r4), 32'd1);
`endif

        // Skip sequence on the 100-cycle instance.
        drive(1, 0, 32'h0, 0); step(); step();
        drive(0, 1, 32'h40490FDB, 0); step();
        chk("skip first char", 32'(c100), 32'h40);
        drive(0, 0, 32'h0, 1); step();
        chk("skip byte2", 32'(c100), 32'h49);
        step();
        chk("skip byte1", 32'(c100), 32'h0F);
        step();
        chk("skip byte0", 32'(c100), 32'hDB);
        chk("skip idx0", 32'(i100), 32'd0);
        drive(0, 0, 32'h0, 0);
        for (int k = 1; k < 100; k++) begin
            step();
            chk($sformatf("skip hold%0d char", k), 32'(c100), 32'hDB);
            chk($sformatf("skip hold%0d done", k), 32'(d100), 32'd0);
        end
        step();
        chk("skip final done", 32'(d100), 32'd1);
        $display("skip sequence: char=%h done=%0b busy=%0b", c100, d100, b100);
        step();
        chk("skip done one-shot", 32'(d100), 32'd0);

`ifdef FP_DISP_SEQ_LOOP_EN
        // Wrap 0->3 with one done per pass, then replace the word during byte 1.
        drive(1, 0, 32'h0, 0); step();
        drive(0, 1, 32'h40490FDB, 0); step();
        drive(0, 0, 32'h0, 0);
        chk("loop ready in show", 32'(r4), 32'd1);
        done_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (d4 === 1'b1) done_cnt++;
        end
        chk("loop wrap done", 32'(d4), 32'd1);
        chk("loop wrap char", 32'(c4), 32'h40);
        chk("loop wrap idx", 32'(i4), 32'd3);
        chk("loop wrap busy", 32'(b4), 32'd1);
        chk("loop done count pass1", 32'(done_cnt), 32'd1);
        for (int k = 0; k < 8; k++) step();
        chk("loop second pass idx1", 32'(i4), 32'd1);
        chk("loop second pass char", 32'(c4), 32'h0F);
        drive(0, 1, 32'hC0000000, 0); step();
        drive(0, 0, 32'h0, 0);
        chk("loop replace char", 32'(c4), 32'hC0);
        chk("loop replace idx", 32'(i4), 32'd3);
        chk("loop replace done", 32'(d4), 32'd0);
        $display("loop sequence: char=%h idx=%0d busy=%0b", c4, i4, b4);
`else
        done_cnt = 0;
        chk("oneshot done count", 32'(done_cnt), 32'(d4));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_disp_seq.md
# fp_result_disp_seq

Display sequencer that presents a 32-bit FPU result on the two-digit seven-segment display one byte at a time. It captures a result word through a valid/ready handshake and steps through its four bytes MSB-first, holding each for a programmable dwell time. Its `char` output feeds the 8-bit character input of the seven-segment display driver. It sits between the FPU result register and the display driver on the board-level top.

## Interface
- `DWELL_CYCLES`, default 50000000: clock cycles each byte is shown. Legal range is 1 to 2^32-1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `result`  in  32  FPU result word; sampled only on handshake.
- `result_valid`  in  1  result is available.
- `result_ready`  out  1  block can accept a result this cycle.
- `next`  in  1  single-cycle pulse (debounced button) that skips to the next byte.
- `char`  out  8  byte shown on the display; connects to the driver's `char` input.
- `byte_idx`  out  2  index of the byte currently shown (3 = bits 31:24, 0 = bits 7:0).
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- **States:** IDLE and SHOW.
- **Registers:**
  - 32-bit word register.
  - 2-bit byte index.
  - 32-bit dwell counter.
- **Reset:** all outputs and state return to reset values on the next rising edge.
  - State = IDLE.
  - `char` = 8'h00, `byte_idx` = 2'd3.
  - `busy` = 0, `done` = 0, `result_ready` = 1.
  - Word register = 0, dwell counter = 0.
- **IDLE:**
  - `result_ready` = 1.
  - On `result_valid`, capture `result` and set `byte_idx` = 3, dwell counter = 0.
  - Move to SHOW.
  - `char` keeps its last value while idle.
- **SHOW:**
  - `char` = byte `byte_idx` of the word register. `busy` = 1.
  - The dwell counter increments each cycle.
- **Advance:** occurs when the dwell counter reaches DWELL_CYCLES-1, or when `next` = 1.
  - If `byte_idx` > 0: decrement `byte_idx` and clear the counter.
  - If `byte_idx` = 0: sequence ends (see Configuration).
- **Simultaneous events:**
  - Dwell expiry together with `next` gives exactly one advance.
  - `next` in IDLE is ignored.
  - `rst` overrides every other input.
- **Reset mid-sequence:** the sequence is abandoned and `char` returns to 8'h00. No `done` pulse is generated.

## Timing
- **Handshake:** a transfer occurs on a rising edge where `result_valid` and `result_ready` are both 1.
  - The first byte appears on `char` in the cycle after that edge (1-cycle latency).
  - `busy` rises in the same cycle as the first byte.
- **Dwell:** each byte is held for exactly DWELL_CYCLES cycles unless cut short by `next`.
  - A full sequence without `next` lasts 4×DWELL_CYCLES cycles.
- **Skip via `next`:** a pulse sampled at edge N shows the new byte from cycle N+1.
- **Completion (one-shot):**
  - `done` = 1 for the first cycle after the final byte's last dwell cycle.
  - In that same cycle, `busy` = 0 and `result_ready` = 1.
  - A result can be accepted in that same cycle (back-to-back operation).
- **Registered outputs:** all outputs come from registers except `result_ready`, which decodes combinationally from state (and from the macro).
- **Minimum dwell:** with DWELL_CYCLES = 1, each byte is shown for one cycle.

## Configuration
- Macro: `FP_DISP_SEQ_LOOP_EN`.
- **Undefined (one-shot):**
  - After byte 0, return to IDLE and pulse `done`.
  - `char` keeps the value of byte 0.
  - `result_ready` = 0 throughout SHOW, and `result_valid` is ignored there.
- **Defined (loop):**
  - After byte 0, wrap to `byte_idx` = 3 and stay in SHOW. `done` pulses once per completed pass.
  - `result_ready` = 1 in SHOW as well.
  - A handshake in SHOW replaces the word register, sets `byte_idx` = 3 and clears the counter. The new byte 3 is shown the next cycle.
  - The block leaves SHOW only on `rst`.

## Test plan
1. **Reset values:** assert `rst` for 2 cycles.
   - Expect `char` = 00, `byte_idx` = 3, `busy` = 0, `done` = 0, `result_ready` = 1.
2. **Full sequence:** DWELL_CYCLES = 4; send `result` = 32'h40490FDB with valid for 1 cycle.
   - Expect `char` = 40, 49, 0F, DB, each for exactly 4 cycles.
   - Expect a 1-cycle `done` after cycle 16; `char` then holds DB.
3. **Skip:** DWELL_CYCLES = 100; pulse `next` on cycles 2, 3 and 4 after accept.
   - Expect bytes 3→2→1→0 advancing on consecutive cycles.
   - Expect byte 0 held for 100 cycles, then `done`.
4. **Collision and back-to-back:** pulse `next` in the same cycle as dwell expiry.
   - Expect a single advance.
   - Expect a new result presented during the `done` cycle to be accepted with no gap.
5. **Mid-sequence reset:** assert `rst` while on byte 2.
   - Expect `char` = 00 and `busy` = 0 on the next cycle, with no `done` pulse.
6. **Loop mode (`FP_DISP_SEQ_LOOP_EN`):** verify wrap 0→3 with `done` once per pass.
   - Send 32'hC0000000 during byte 1: expect `char` = C0 on the next cycle.
   - One-shot build: verify `result_ready` = 0 and valid ignored during SHOW.
